// File: rtl/seq_chunk_multiplier_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int digit_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width for digit indices; a single-digit operand still needs one bit.
    function automatic int index_width(input int width, input int chunk);
        int d;
        d = width / chunk;
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_multiplier_if.sv
// Request/response bundle between a multiplier client and the multiplier.
interface seq_chunk_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               accumulate;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] res;

    modport master (output start, accumulate, A, B, input busy, done, res);
    modport slave  (input start, accumulate, A, B, output busy, done, res);
endinterface

// File: rtl/seq_chunk_mult_ctrl.sv
// Controller: IDLE/CALC/DONE sequencing and the i (outer) / j (inner) digit counters.
module seq_chunk_mult_ctrl
    import mult_pkg::*;
#(
    parameter int D  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          accumulate,
    output logic [IW-1:0] i_sel,
    output logic [IW-1:0] j_sel,
    output logic          load_ops,
    output logic          clear_res,
    output logic          ld_res,
    output logic          busy,
    output logic          done
);

    localparam logic [IW-1:0] LAST = IW'(D - 1);

    state_t state;

    // Acceptance must act on the same edge that leaves IDLE, so it is decoded, not registered.
    assign load_ops  = (state == IDLE) && start;
    assign clear_res = load_ops && !accumulate;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            i_sel  <= '0;
            j_sel  <= '0;
            ld_res <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= CALC;
                        i_sel  <= '0;
                        j_sel  <= '0;
                        ld_res <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                CALC: begin
                    if (j_sel == LAST) begin
                        j_sel <= '0;
                        if (i_sel == LAST) begin
                            i_sel  <= '0;
                            state  <= DONE;
                            ld_res <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            i_sel <= i_sel + 1'b1;
                        end
                    end else begin
                        j_sel <= j_sel + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ld_res <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_chunk_multiplier.sv
// Sequential multiplier: one CHUNKxCHUNK partial product per cycle, shifted and summed into res.
module seq_chunk_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_chunk_multiplier_if.slave bus
);

    localparam int D  = digit_count(WIDTH, CHUNK);
    localparam int IW = index_width(WIDTH, CHUNK);

    logic [IW-1:0]      i_sel;
    logic [IW-1:0]      j_sel;
    logic               load_ops;
    logic               clear_res;
    logic               ld_res;
    logic               busy;
    logic               done;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CHUNK-1:0]   a_dig;
    logic [CHUNK-1:0]   b_dig;
    logic [2*CHUNK-1:0] pp;
    logic [2*WIDTH-1:0] pp_shifted;
    logic [2*WIDTH-1:0] res_q;

    seq_chunk_mult_ctrl #(
        .D  (D),
        .IW (IW)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (bus.start),
        .accumulate (bus.accumulate),
        .i_sel      (i_sel),
        .j_sel      (j_sel),
        .load_ops   (load_ops),
        .clear_res  (clear_res),
        .ld_res     (ld_res),
        .busy       (busy),
        .done       (done)
    );

    // Digit select by shifting keeps the index in range even for a single-digit operand.
    assign a_dig      = CHUNK'(a_reg >> (int'(i_sel) * CHUNK));
    assign b_dig      = CHUNK'(b_reg >> (int'(j_sel) * CHUNK));
    assign pp         = (2*CHUNK)'(a_dig) * (2*CHUNK)'(b_dig);
    assign pp_shifted = (2*WIDTH)'(pp) << ((int'(i_sel) + int'(j_sel)) * CHUNK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg <= '0;
            b_reg <= '0;
            res_q <= '0;
        end else if (load_ops) begin
            a_reg <= bus.A;
            b_reg <= bus.B;
            if (clear_res) begin
                res_q <= '0;
            end
        end else if (ld_res) begin
            // Accumulation wraps modulo 2^(2*WIDTH); the carry out is intentionally dropped.
            res_q <= res_q + pp_shifted;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.res  = res_q;

endmodule

// File: tb/tb_seq_chunk_multiplier.sv
// Directed scoreboard bench for three multiplier configurations (8/2, 16/4, 8/8).
module tb_seq_chunk_multiplier;

    logic        clk;
    logic        rst_v;
    int          sel;
    logic        start_v;
    logic        acc_v;
    logic [15:0] a_v;
    logic [15:0] b_v;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] sb [$];
    logic [31:0] model [3];

    logic        obs_busy;
    logic        obs_done;
    logic [31:0] obs_res;

    seq_chunk_multiplier_if #(.WIDTH(8))  if8();
    seq_chunk_multiplier_if #(.WIDTH(16)) if16();
    seq_chunk_multiplier_if #(.WIDTH(8))  if88();

    assign if8.start       = (sel == 0) ? start_v : 1'b0;
    assign if8.accumulate  = acc_v;
    assign if8.A           = a_v[7:0];
    assign if8.B           = b_v[7:0];
    assign if16.start      = (sel == 1) ? start_v : 1'b0;
    assign if16.accumulate = acc_v;
    assign if16.A          = a_v;
    assign if16.B          = b_v;
    assign if88.start      = (sel == 2) ? start_v : 1'b0;
    assign if88.accumulate = acc_v;
    assign if88.A          = a_v[7:0];
    assign if88.B          = b_v[7:0];

    seq_chunk_multiplier #(.WIDTH(8), .CHUNK(2)) u8 (
        .clk (clk),
        .rst (rst_v),
        .bus (if8.slave)
    );

    seq_chunk_multiplier #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk (clk),
        .rst (rst_v),
        .bus (if16.slave)
    );

    seq_chunk_multiplier #(.WIDTH(8), .CHUNK(8)) u88 (
        .clk (clk),
        .rst (rst_v),
        .bus (if88.slave)
    );

    always_comb begin
        obs_busy = 1'b0;
        obs_done = 1'b0;
        obs_res  = '0;
        case (sel)
            0: begin obs_busy = if8.busy;  obs_done = if8.done;  obs_res = 32'(if8.res);  end
            1: begin obs_busy = if16.busy; obs_done = if16.done; obs_res = if16.res;      end
            2: begin obs_busy = if88.busy; obs_done = if88.done; obs_res = 32'(if88.res); end
            default: ;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a request in an IDLE cycle; the model result goes on the scoreboard. Returns in cycle 1.
    task automatic issue(input int s, input logic [15:0] a, input logic [15:0] b, input logic acc);
        logic [31:0] mask;
        sel     = s;
        start_v = 1'b1;
        a_v     = a;
        b_v     = b;
        acc_v   = acc;
        mask    = (s == 1) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        model[s] = ((acc ? model[s] : 32'h0) + 32'(a) * 32'(b)) & mask;
        sb.push_back(model[s]);
        @(negedge clk);
    endtask

    // Follow a run from cycle 1 to the cycle after DONE; junk operands appear mid-run.
    task automatic follow(input int n, input bit keep_start, input logic [15:0] ja, input logic [15:0] jb);
        logic [31:0] exp_res;
        if (!keep_start) start_v = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) begin
                a_v   = ja;
                b_v   = jb;
                acc_v = ~acc_v;
            end
            check($sformatf("calc_c%0d", c), {30'h0, obs_busy, obs_done}, 32'h2);
        end
        @(negedge clk);
        check("done_pulse", {30'h0, obs_busy, obs_done}, 32'h3);
        exp_res = sb.pop_front();
        check("res_at_done", obs_res, exp_res);
        @(negedge clk);
        check("idle_after", {30'h0, obs_busy, obs_done}, 32'h0);
        check("res_hold", obs_res, exp_res);
    endtask

    initial begin
        rst_v   = 1'b0;
        sel     = 0;
        start_v = 1'b0;
        acc_v   = 1'b0;
        a_v     = 16'h0;
        b_v     = 16'h0;
        for (int s = 0; s < 3; s++) model[s] = '0;

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("rst_flags_%0d", s), {30'h0, obs_busy, obs_done}, 32'h0);
            check($sformatf("rst_res_%0d", s), obs_res, 32'h0);
        end
        rst_v = 1'b1;
        @(negedge clk);

        // 8-bit / 2-bit digits: 16 adds, done in cycle 17
        issue(0, 16'h00FF, 16'h00FF, 1'b0);
        follow(16, 1'b0, 16'h0012, 16'h0034);
        issue(0, 16'h00FF, 16'h00FF, 1'b1);
        follow(16, 1'b0, 16'h0000, 16'h0000);
        issue(0, 16'h0002, 16'h0003, 1'b0);
        follow(16, 1'b0, 16'h00AA, 16'h0055);

        // start held through a run: mid-run operands must wait for the next IDLE visit
        issue(0, 16'h0000, 16'h005A, 1'b0);
        follow(16, 1'b1, 16'h0011, 16'h0022);
        issue(0, 16'h0011, 16'h0022, 1'b0);
        follow(16, 1'b0, 16'h0000, 16'h0000);

        // reset in cycle 8 of a run discards the partial result
        issue(0, 16'h0037, 16'h0059, 1'b0);
        start_v = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("pre_abort_c%0d", c), {30'h0, obs_busy, obs_done}, 32'h2);
        end
        rst_v = 1'b0;
        @(negedge clk);
        check("abort_flags", {30'h0, obs_busy, obs_done}, 32'h0);
        check("abort_res", obs_res, 32'h0);
        void'(sb.pop_front());
        for (int s = 0; s < 3; s++) model[s] = '0;
        rst_v = 1'b1;
        @(negedge clk);
        check("abort_idle", {30'h0, obs_busy, obs_done}, 32'h0);
        issue(0, 16'h000C, 16'h000B, 1'b0);
        follow(16, 1'b0, 16'h00FF, 16'h00FF);

        // 16-bit / 4-bit digits
        issue(1, 16'hABCD, 16'h1234, 1'b0);
        follow(16, 1'b0, 16'hFFFF, 16'hFFFF);

        // single digit: one add, done in cycle 2
        issue(2, 16'h0010, 16'h0010, 1'b0);
        follow(1, 1'b0, 16'h0000, 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_chunk_multiplier.md
Name: seq_chunk_multiplier

Overview:
Parametrised sequential multiplier. It multiplies two unsigned WIDTH-bit operands by iterating over CHUNK×CHUNK digit pairs. Each cycle it adds one shifted partial product into a 2*WIDTH-bit result register. It generalises the fixed 4×4 / 2-bit-digit multiplier datapath to any width and digit size, and adds an integrated controller, a start/busy/done handshake and an optional accumulate (MAC) mode. It is the arithmetic building block for the complex-multiplier top level.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of CHUNK and ≥ CHUNK.
CHUNK, 2, digit width of the combinational partial-product multiplier.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
accumulate  input  1  sampled with start; 1 = add product onto current res, 0 = clear res first.
A  input  WIDTH  operand A; captured on an accepted start.
B  input  WIDTH  operand B; captured on an accepted start.
busy  output  1  high in CALC and DONE.
done  output  1  one-cycle pulse; res is final in that cycle.
res  output  2*WIDTH  result / accumulator register.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, res=0, done=0, busy=0, operand registers=0, digit indices=0.
  - Reset overrides all other inputs, including mid-operation; a partial result is discarded.
- D = WIDTH/CHUNK digits per operand; N = D*D iterations.
- States:
  - IDLE: start=1 at an edge → capture A and B, i=j=0, res=0 (or unchanged if accumulate=1), go to CALC. start=0 → stay; res holds.
  - CALC: each edge adds pp = Adig[i]*Bdig[j], zero-extended and shifted left by (i+j)*CHUNK, into res.
    - Addition is modulo 2^(2*WIDTH); carry out is dropped.
    - j is the inner index, 0..D-1; i is the outer index. After (i,j)=(D-1,D-1) the next state is DONE.
  - DONE: done=1 for exactly this cycle; res is not modified; next state is IDLE.
- Latency: start accepted at edge 0 → CALC occupies cycles 1..N, with adds at edges 1..N → done=1 during cycle N+1. A new start can be accepted at the edge ending the DONE cycle's successor (IDLE). Minimum issue interval: N+2 cycles.
- start is ignored while busy=1. A, B and accumulate are don't-care except in the accepting cycle.
- res stays stable from DONE until the next accepted start.
- With accumulate=0, res holds the exact product (never overflows). With accumulate=1, res wraps.
- Digit extraction: Adig[k] = A_reg[k*CHUNK +: CHUNK].

Decomposition:
- Shared package (mult_pkg):
  - state enum {IDLE, CALC, DONE};
  - function/localparam for digit count D and index width $clog2(D) (minimum 1).
- One natural sub-module, seq_chunk_mult_ctrl: the FSM plus i/j counters. Outputs digit selects, clearRes, ldRes, busy, done.
- Datapath: operand registers, digit muxes, the CHUNK×CHUNK multiply, the shifter and the adder. It stays in seq_chunk_multiplier, reusing the existing register and adder cells.

Test Plan:
- WIDTH=8, CHUNK=2, start with A=0xFF, B=0xFF, accumulate=0 → busy high for cycles 1..17; done pulse in cycle 17 only; res=0xFE01.
- Then start with A=0xFF, B=0xFF, accumulate=1 → res=0xFC02 (0x1FC02 wrapped); then A=0x02, B=0x03, accumulate=0 → res=0x0006.
- A=0x00, B=0x5A → res=0x0000 with done in cycle 17. start held high continuously through a run → only one run per IDLE visit, no restart while busy; the new A/B presented mid-run must not be captured.
- Reset low during cycle 8 of a CALC run → next cycle state IDLE, res=0, busy=0, done=0; a subsequent start with A=0x0C, B=0x0B → res=0x0084.
- WIDTH=16, CHUNK=4, A=0xABCD, B=0x1234 → done in cycle 17, res=0x0C374FA4.
- WIDTH=8, CHUNK=8 (D=1) → A=0x10, B=0x10 gives res=0x0100 with done in cycle 2.
